// File: rtl/idli_stall_m.sv
// idli core stall controller: per-channel resource checks gate the core clock,
// with cause capture, force-open override, consecutive-stall watchdog and stall counter.
module idli_stall_m #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned TIMEOUT  = 200,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      i_stall_gck,
  input  logic                      i_stall_rst_n,
  input  logic                      i_stall_ex_vld,
  input  logic [CTR_W-1:0]          i_stall_ex_ctr,
  input  logic [CHANNELS-1:0]       i_stall_req,
  input  logic [CHANNELS*CTR_W-1:0] i_stall_sel,
  input  logic [CHANNELS-1:0]       i_stall_rdy,
  input  logic [CHANNELS-1:0]       i_stall_en,
  input  logic                      i_stall_force,
  input  logic                      i_stall_clr,
  output logic                      o_stall_gck,
  output logic                      o_stall_active,
  output logic [CHANNELS-1:0]       o_stall_cause,
  output logic                      o_stall_timeout,
  output logic [CNT_W-1:0]          o_stall_cycles
);

  localparam logic [15:0] RUN_MAX = 16'(TIMEOUT);

  logic [CHANNELS-1:0] w_stall;
  logic                w_stall_any;
  logic                w_stalled;
  logic [15:0]         w_run_inc;

  logic                r_gate;
  logic [CHANNELS-1:0] r_cause;
  logic [15:0]         r_run;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_cycles;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign w_stall[c] = i_stall_en[c] & i_stall_ex_vld &
                        (i_stall_ex_ctr == i_stall_sel[c*CTR_W +: CTR_W]) &
                        i_stall_req[c] & ~i_stall_rdy[c];
  end

  assign w_stall_any = (|w_stall) & ~i_stall_force;

  // Gate state moves only while the clock is low, so the AND gate cannot glitch.
  always_ff @(negedge i_stall_gck) begin
    if (!i_stall_rst_n) begin
      r_gate  <= 1'b1;
      r_cause <= '0;
    end else begin
      r_gate  <= ~w_stall_any;
      r_cause <= i_stall_force ? '0 : w_stall;
    end
  end

  assign w_stalled = ~r_gate;
  assign w_run_inc = r_run + 16'd1;

  always_ff @(posedge i_stall_gck) begin
    if (!i_stall_rst_n) begin
      r_run     <= '0;
      r_timeout <= 1'b0;
      r_cycles  <= '0;
    end else begin
      if (!w_stalled)
        r_run <= '0;
      else if (r_run != RUN_MAX)
        r_run <= w_run_inc;

      if (w_stalled && (w_run_inc == RUN_MAX))
        r_timeout <= 1'b1;
      else if (i_stall_clr)
        r_timeout <= 1'b0;

      if (i_stall_clr)
        r_cycles <= w_stalled ? CNT_W'(1) : '0;
      else if (w_stalled && !(&r_cycles))
        r_cycles <= r_cycles + CNT_W'(1);
    end
  end

  assign o_stall_gck     = i_stall_gck & r_gate;
  assign o_stall_active  = ~r_gate;
  assign o_stall_cause   = r_cause;
  assign o_stall_timeout = r_timeout;
  assign o_stall_cycles  = r_cycles;

endmodule
